// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator sequencer driving a 4-bit combinational ALU
module alu_seq #(
  parameter logic [3:0] ACC_INIT = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_b,
  input  logic [1:0] cmd_cnt,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_acc,
  output logic       res_z,
  output logic       res_v,
  output logic       res_vs,
  output logic       alu_a0,
  output logic       alu_a1,
  output logic       alu_a2,
  output logic       alu_a3,
  output logic       alu_b0,
  output logic       alu_b1,
  output logic       alu_b2,
  output logic       alu_b3,
  output logic       alu_s0,
  output logic       alu_s1,
  output logic       alu_s2,
  output logic       alu_s3,
  input  logic       alu_y0,
  input  logic       alu_y1,
  input  logic       alu_y2,
  input  logic       alu_y3,
  input  logic       alu_z,
  input  logic       alu_v
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] acc, op_q, b_q;
  logic [1:0] rem;
  logic       load_q, z_q, v_q, vs_q;
  logic [3:0] alu_y;
  logic       asr_again;

  // ALU pins are numbered MSB-first: pin 0 carries bit 3
  assign alu_y  = {alu_y0, alu_y1, alu_y2, alu_y3};
  assign alu_a0 = acc[3];
  assign alu_a1 = acc[2];
  assign alu_a2 = acc[1];
  assign alu_a3 = acc[0];
  assign alu_b0 = b_q[3];
  assign alu_b1 = b_q[2];
  assign alu_b2 = b_q[1];
  assign alu_b3 = b_q[0];
  assign alu_s0 = op_q[0];
  assign alu_s1 = op_q[1];
  assign alu_s2 = op_q[2];
  assign alu_s3 = op_q[3];

  assign res_acc = acc;
  assign res_z   = z_q;
  assign res_v   = v_q;
  assign res_vs  = vs_q;

  assign asr_again = op_q[3] && !load_q && (rem != 2'd0);

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (!asr_again) state_nxt = DONE;
      end
      DONE: begin
        res_valid = rst_n;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= ACC_INIT;
      z_q    <= (ACC_INIT == 4'b0000);
      v_q    <= 1'b0;
      vs_q   <= 1'b0;
      op_q   <= 4'b0000;
      b_q    <= 4'b0000;
      rem    <= 2'd0;
      load_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            b_q    <= cmd_b;
            rem    <= cmd_cnt;
            load_q <= cmd_load;
          end
        end
        EXEC: begin
          if (load_q) begin
            acc  <= b_q;
            z_q  <= (b_q == 4'b0000);
            v_q  <= 1'b0;
            vs_q <= 1'b0;
          end else begin
            acc  <= alu_y;
            z_q  <= alu_z;
            v_q  <= alu_v;
            vs_q <= vs_q | alu_v;
            if (asr_again) rem <= rem - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq with a behavioural ALU attached
module tb_alu_seq;

  typedef struct {
    logic [3:0] acc;
    logic       z;
    logic       v;
    logic       vs;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_load = 1'b0;
  logic [3:0] cmd_op = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [1:0] cmd_cnt = 2'd0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_acc;
  logic       res_z, res_v, res_vs;
  logic       alu_a0, alu_a1, alu_a2, alu_a3;
  logic       alu_b0, alu_b1, alu_b2, alu_b3;
  logic       alu_s0, alu_s1, alu_s2, alu_s3;
  logic       alu_y0, alu_y1, alu_y2, alu_y3, alu_z, alu_v;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   seen = 1'b0;
  int   rr_mode = 0;
  exp_t exp_q[$];
  logic [3:0] m_acc = 4'b0000;
  logic       m_vs = 1'b0;

  alu_seq #(.ACC_INIT(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
    .res_valid(res_valid), .res_ready(res_ready), .res_acc(res_acc),
    .res_z(res_z), .res_v(res_v), .res_vs(res_vs),
    .alu_a0(alu_a0), .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_a3(alu_a3),
    .alu_b0(alu_b0), .alu_b1(alu_b1), .alu_b2(alu_b2), .alu_b3(alu_b3),
    .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_s2(alu_s2), .alu_s3(alu_s3),
    .alu_y0(alu_y0), .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_y3(alu_y3),
    .alu_z(alu_z), .alu_v(alu_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational ALU on the pin side of the sequencer
  logic [3:0] pa, pb, ps, py;
  logic [4:0] psum;
  always_comb begin
    pa   = {alu_a0, alu_a1, alu_a2, alu_a3};
    pb   = {alu_b0, alu_b1, alu_b2, alu_b3};
    ps   = {alu_s3, alu_s2, alu_s1, alu_s0};
    py   = 4'd0;
    psum = 5'd0;
    if (ps[3]) py = {pa[3], pa[3:1]};
    else if (!ps[2]) begin
      case (ps[1:0])
        2'b00:   py = pa & pb;
        2'b10:   py = pa | pb;
        2'b01:   py = pa ^ pb;
        default: py = ~pb;
      endcase
    end else begin
      psum = {1'b0, pa} + {1'b0, (ps[0] ? pb : ~pb)} + {4'd0, ps[1]};
      py   = psum[3:0];
    end
  end
  assign {alu_y0, alu_y1, alu_y2, alu_y3} = py;
  assign alu_z = (py == 4'd0);
  assign alu_v = psum[4] & ps[0] & ps[2] & ~ps[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input logic ld, input logic [3:0] op, input logic [3:0] b,
                       input logic [1:0] cnt, output exp_t e);
    int s;
    logic signed [3:0] sa;
    e.lat = 1;
    e.v   = 1'b0;
    if (ld) begin
      m_acc = b;
      m_vs  = 1'b0;
    end else if (op[3]) begin
      sa = m_acc;
      for (int i = 0; i <= int'(cnt); i++) sa = sa >>> 1;
      m_acc = sa;
      e.lat = int'(cnt) + 1;
    end else if (!op[2]) begin
      case (op[1:0])
        2'b00:   m_acc = m_acc & b;
        2'b10:   m_acc = m_acc | b;
        2'b01:   m_acc = m_acc ^ b;
        default: m_acc = ~b;
      endcase
    end else begin
      s = int'(m_acc) + (op[0] ? int'(b) : 15 - int'(b)) + int'(op[1]);
      m_acc = s[3:0];
      e.v = op[0] && (s > 15);
    end
    m_vs  = m_vs | e.v;
    e.acc = m_acc;
    e.z   = (m_acc == 4'd0);
    e.vs  = m_vs;
  endtask

  // Caller is aligned just after a rising edge; returns the same way
  task automatic send(input logic ld, input logic [3:0] op, input logic [3:0] b, input logic [1:0] cnt);
    exp_t e;
    bit   ok = 1'b0;
    cmd_load = ld; cmd_op = op; cmd_b = b; cmd_cnt = cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (ok) begin
      model(ld, op, b, cnt, e);
      exp_q.push_back(e);
    end else check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: every cycle a result is shown it must match the queue head
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else begin
      if (res_valid) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else begin
          if (!seen) begin
            check("latency", cyc - acc_cyc, exp_q[0].lat);
            seen = 1'b1;
          end
          check("res_acc", res_acc, exp_q[0].acc);
          check("res_z", res_z, exp_q[0].z);
          check("res_v", res_v, exp_q[0].v);
          check("res_vs", res_vs, exp_q[0].vs);
          check("cmd_ready_busy", cmd_ready, 1'b0);
          if (res_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
    end
  end

  initial begin
    #2000000;
    check("watchdog", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("init_acc", res_acc, 4'b0000);
    check("init_z", res_z, 1'b1);
    check("init_v", res_v, 1'b0);
    check("init_vs", res_vs, 1'b0);
    check("init_res_valid", res_valid, 1'b0);
    check("init_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    send(1'b1, 4'b0000, 4'b1100, 2'd0);
    send(1'b0, 4'b0101, 4'b0101, 2'd0);
    wait_idle();
    check("add_acc", res_acc, 4'b0001);
    check("add_v", res_v, 1'b1);
    check("add_vs", res_vs, 1'b1);
    check("add_z", res_z, 1'b0);

    send(1'b1, 4'b0000, 4'b0101, 2'd0);
    send(1'b0, 4'b0110, 4'b0101, 2'd0);
    wait_idle();
    check("sub_acc", res_acc, 4'b0000);
    check("sub_z", res_z, 1'b1);
    check("sub_v", res_v, 1'b0);

    send(1'b1, 4'b0000, 4'b1010, 2'd0);
    send(1'b0, 4'b1000, 4'b0000, 2'd1);
    wait_idle();
    check("asr1_acc", res_acc, 4'b1110);
    send(1'b1, 4'b0000, 4'b1010, 2'd0);
    send(1'b0, 4'b1000, 4'b0000, 2'd3);
    wait_idle();
    check("asr3_acc", res_acc, 4'b1111);

    send(1'b1, 4'b0000, 4'b0110, 2'd0);
    wait_idle();
    rr_mode = 2;
    fork
      begin
        send(1'b0, 4'b0001, 4'b0011, 2'd0);
        send(1'b0, 4'b0011, 4'b1001, 2'd0);
      end
      begin
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (res_valid) begin got = 1'b1; break; end
        end
        check("bp_res_seen", got, 1'b1);
        for (int i = 0; i < 5; i++) begin
          check("bp_xor_acc", res_acc, 4'b0101);
          check("bp_cmd_ready", cmd_ready, 1'b0);
          check("bp_res_valid", res_valid, 1'b1);
          @(negedge clk);
        end
        rr_mode = 0;
      end
    join
    wait_idle();
    check("bp_next_acc", res_acc, 4'b0110);

    rr_mode = 1;
    for (int n = 0; n < 150; n++) begin
      send(($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_mode = 0;
    wait_idle();

    send(1'b1, 4'b0000, 4'b1010, 2'd0);
    wait_idle();
    cmd_load = 1'b0; cmd_op = 4'b1000; cmd_b = 4'b0000; cmd_cnt = 2'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("rst_test_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready", cmd_ready, 1'b0);
    check("midrst_res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_acc = 4'b0000;
    m_vs  = 1'b0;
    @(negedge clk);
    check("postrst_acc", res_acc, 4'b0000);
    check("postrst_z", res_z, 1'b1);
    check("postrst_vs", res_vs, 1'b0);
    check("postrst_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("postrst_no_result", res_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send(1'b0, 4'b0101, 4'b0011, 2'd0);
    wait_idle();
    check("postrst_add_acc", res_acc, 4'b0011);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Accumulator sequencer placed directly upstream of the 4-bit combinational ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU's bit-level operand and select pins from registered state. It captures the ALU's result and flags back into a 4-bit accumulator, repeating arithmetic-shift-right commands for a programmed count. Each result is presented on a valid/ready output channel that holds under backpressure.

## Interface
- ACC_INIT, 4'b0000, accumulator value after reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_load  in  1  1 = load accumulator with cmd_b; cmd_op ignored
- cmd_op  in  4  ALU select; [3]=s3, [2]=s2, [1]=s1, [0]=s0
- cmd_b  in  4  B operand / load value ([3]=MSB)
- cmd_cnt  in  2  extra ASR repetitions (ASR runs cmd_cnt+1 times); ignored unless cmd_op[3]=1
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_acc  out  4  accumulator ([3]=MSB), continuously driven
- res_z  out  1  zero flag of last operation
- res_v  out  1  ALU v of last operation
- res_vs  out  1  sticky OR of res_v since last load/reset
- alu_a0..alu_a3  out  1 each  ALU A pins; alu_a0=acc[3] (MSB) … alu_a3=acc[0] (LSB)
- alu_b0..alu_b3  out  1 each  ALU B pins; same MSB-first mapping from latched B
- alu_s0..alu_s3  out  1 each  latched op bits [0]..[3]
- alu_y0..alu_y3, alu_z, alu_v  in  1 each  ALU outputs; alu_y0 is MSB

## Operation
- ALU encoding (fixed): s3=1 → ASR of A (MSB replicated); s3=0,s2=0 → s1s0 00 AND, 10 OR, 01 XOR, 11 ~B; s3=0,s2=1 → A + (s0 ? B : ~B) + s1. ALU v = carry-out gated by s0&s2&~s3.
- FSM states IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_op, cmd_b, cmd_cnt into rem, and cmd_load → EXEC.
- EXEC (cmd_ready=0): ALU pins are driven from the accumulator and latched registers; the ALU is combinational, so its result is valid in the same cycle.
  - Load: acc←B, z←(B==0), v←0, vs←0 → DONE.
  - Otherwise: acc←{y0,y1,y2,y3}, z←alu_z, v←alu_v, vs←vs|alu_v.
  - If op[3]=1 and rem≠0: rem←rem−1, stay in EXEC. Else → DONE.
- DONE: res_valid=1. Outputs are stable until the res_valid&res_ready edge, then → IDLE.
- Any op with s3=1 is ASR regardless of s2..s0; v is captured as delivered (0).
- ALU pins hold their last latched values in IDLE/DONE; they never float.
- Reset (rst_n=0 at an edge): state←IDLE, acc←ACC_INIT, res_z←(ACC_INIT==0), res_v←0, res_vs←0, latched op/b/rem←0. While rst_n=0, cmd_ready=0 and res_valid=0 combinationally.
- Reset mid-EXEC or mid-DONE abandons the command; no result is delivered.

## Timing
- Command accepted at edge k. Non-ASR/load: EXEC during cycle k..k+1; res_valid high from edge k+1.
- ASR with cmd_cnt=n: n+1 EXEC cycles; res_valid high from edge k+n+1.
- Earliest next accept: the edge after the res handshake. Minimum 3 cycles per command, since IDLE lasts ≥1 cycle.
- cmd_valid while busy is ignored; the source holds its command stable until cmd_ready.
- res_ready held high before res_valid: the handshake completes on the first DONE edge.
- res_acc/res_z/res_v/res_vs change only at EXEC edges and reset.

## Test plan
- Reset with ACC_INIT=0 → res_acc=0000, res_z=1, res_v=0, res_vs=0, res_valid=0; cmd_ready=1 the cycle after rst_n rises.
- Load 1100, then op 0101 (A+B), B=0101 → res_acc=0001, res_v=1, res_vs=1, res_z=0; res_valid asserted 1 cycle after accept.
- Load 0101, then op 0110 (A−B), B=0101 → res_acc=0000, res_z=1, res_v=0. The next load clears res_vs.
- Load 1010, then op 1000 with cmd_cnt=1 → two EXEC cycles, res_acc=1110. With cmd_cnt=3 → 1111, res_valid 4 cycles after accept.
- Load 0110, op 0001 (XOR) B=0011 → 0101. Hold res_ready low 5 cycles: res_valid and outputs stay stable, cmd_ready=0 throughout, and a pending cmd is not accepted until after the handshake.
- Assert rst_n=0 during the second cycle of an ASR cnt=3 → next cycle state IDLE, res_acc=ACC_INIT, res_valid=0, and no result handshake occurs.
